// File: rtl/sprite_overlay_stack.sv
// N-layer fixed-priority sprite compositor for the VGA pixel path, 3-clock latency.
// Define SPRITE_KEY_EN to make pixels equal to KEY_RGB transparent.
module sprite_overlay_stack #(
   parameter int          N_LAYERS = 4,
   parameter int          SPRITE_W = 64,
   parameter int          SPRITE_H = 64,
   parameter int          ADDR_W   = $clog2(SPRITE_W*SPRITE_H),
   parameter logic [11:0] KEY_RGB  = 12'h0F0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [10:0]                  in_hcount,
   input  logic [10:0]                  in_vcount,
   input  logic                         in_hsync,
   input  logic                         in_vsync,
   input  logic                         in_hblnk,
   input  logic                         in_vblnk,
   input  logic [11:0]                  in_rgb,
   input  logic [N_LAYERS-1:0]          layer_en,
   input  logic [N_LAYERS*12-1:0]       layer_x,
   input  logic [N_LAYERS*12-1:0]       layer_y,
   output logic [N_LAYERS*ADDR_W-1:0]   pixel_addr,
   input  logic [N_LAYERS*12-1:0]       rgb_pixel,
   output logic [10:0]                  out_hcount,
   output logic [10:0]                  out_vcount,
   output logic                         out_hsync,
   output logic                         out_vsync,
   output logic                         out_hblnk,
   output logic                         out_vblnk,
   output logic [11:0]                  out_rgb,
   output logic                         frame_latched
);

`ifdef SPRITE_KEY_EN
   localparam logic KEY_ENABLE = 1'b1;
`else
   localparam logic KEY_ENABLE = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } beat_t;

   beat_t                       s0;
   beat_t                       t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
   logic                        vblnk_prev_q, vblnk_prev_d;
   logic                        vblnk_rise;
   logic [N_LAYERS-1:0]         en_q, en_d;
   logic [N_LAYERS*12-1:0]      x_q, x_d, y_q, y_d;
   logic [N_LAYERS*ADDR_W-1:0]  addr_q, addr_d, addr_s0;
   logic [N_LAYERS-1:0]         hit1_q, hit1_d, hit2_q, hit2_d, hit_s0;
   logic [N_LAYERS-1:0]         key_match, opaque;

   assign s0 = '{hcount: in_hcount, vcount: in_vcount, hsync: in_hsync, vsync: in_vsync,
                 hblnk: in_hblnk, vblnk: in_vblnk, rgb: in_rgb};

   // Window compare is done at 13 bits so a sprite near 4095 never wraps onto column 0.
   for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
      logic [12:0] hc, vc, x_lo, y_lo;
      logic        in_x, in_y;

      assign hc   = {2'b00, in_hcount};
      assign vc   = {2'b00, in_vcount};
      assign x_lo = {1'b0, x_q[i*12 +: 12]};
      assign y_lo = {1'b0, y_q[i*12 +: 12]};
      assign in_x = (hc >= x_lo) && (hc < x_lo + 13'(SPRITE_W));
      assign in_y = (vc >= y_lo) && (vc < y_lo + 13'(SPRITE_H));
      assign hit_s0[i] = en_q[i] && !in_hblnk && !in_vblnk && in_x && in_y;
      assign addr_s0[i*ADDR_W +: ADDR_W] = hit_s0[i]
         ? ADDR_W'(32'(vc - y_lo) * SPRITE_W + 32'(hc - x_lo))
         : '0;
      assign key_match[i] = (rgb_pixel[i*12 +: 12] == KEY_RGB);
   end

   assign opaque = hit2_q & ~(key_match & {N_LAYERS{KEY_ENABLE}});

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      vblnk_rise   = in_vblnk && !vblnk_prev_q;
      vblnk_prev_d = in_vblnk;
      en_d         = en_q;
      x_d          = x_q;
      y_d          = y_q;
      if (vblnk_rise) begin
         en_d = layer_en;
         x_d  = layer_x;
         y_d  = layer_y;
      end

      addr_d = addr_s0;
      hit1_d = hit_s0;
      hit2_d = hit1_q;
      t1_d   = s0;
      t2_d   = t1_q;
      t3_d   = t2_q;
      // Ascending scan: the last (highest-index) opaque layer wins.
      for (int i = 0; i < N_LAYERS; i++) begin
         if (opaque[i]) t3_d.rgb = rgb_pixel[i*12 +: 12];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (rst) begin
         vblnk_prev_q <= 1'b0;
         en_q         <= '0;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         hit1_q       <= '0;
         hit2_q       <= '0;
         t1_q         <= '0;
         t2_q         <= '0;
         t3_q         <= '0;
      end else begin
         vblnk_prev_q <= vblnk_prev_d;
         en_q         <= en_d;
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         hit1_q       <= hit1_d;
         hit2_q       <= hit2_d;
         t1_q         <= t1_d;
         t2_q         <= t2_d;
         t3_q         <= t3_d;
      end
   end

   assign frame_latched = vblnk_rise && !rst;
   assign pixel_addr    = addr_q;
   assign out_hcount    = t3_q.hcount;
   assign out_vcount    = t3_q.vcount;
   assign out_hsync     = t3_q.hsync;
   assign out_vsync     = t3_q.vsync;
   assign out_hblnk     = t3_q.hblnk;
   assign out_vblnk     = t3_q.vblnk;
   assign out_rgb       = t3_q.rgb;

endmodule

// File: tb/tb_sprite_overlay_stack.sv
// Directed bench for sprite_overlay_stack with a registered per-layer ROM model.
// Expected values are hand-computed; KEY colour expectation follows SPRITE_KEY_EN.
module tb_sprite_overlay_stack;

   localparam int N = 4;
   localparam int AW = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [10:0]     in_hcount, in_vcount;
   logic            in_hsync, in_vsync, in_hblnk, in_vblnk;
   logic [11:0]     in_rgb;
   logic [N-1:0]    layer_en;
   logic [11:0]     lx [N];
   logic [11:0]     ly [N];
   logic [N*12-1:0] layer_x, layer_y;
   logic [N*AW-1:0] pixel_addr;
   logic [N*12-1:0] rgb_pixel;
   logic [10:0]     out_hcount, out_vcount;
   logic            out_hsync, out_vsync, out_hblnk, out_vblnk;
   logic [11:0]     out_rgb;
   logic            frame_latched;

   logic [11:0]     rom_q     [N];
   logic [11:0]     rom_const [N];
   logic            use_const [N];

   int checks = 0;
   int errors = 0;

   assign layer_x   = {lx[3], lx[2], lx[1], lx[0]};
   assign layer_y   = {ly[3], ly[2], ly[1], ly[0]};
   assign rgb_pixel = {rom_q[3], rom_q[2], rom_q[1], rom_q[0]};

   sprite_overlay_stack #(.N_LAYERS(N)) dut (
      .clk(clk), .rst(rst),
      .in_hcount(in_hcount), .in_vcount(in_vcount),
      .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
      .in_rgb(in_rgb), .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y),
      .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
      .out_hcount(out_hcount), .out_vcount(out_vcount),
      .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk),
      .out_rgb(out_rgb), .frame_latched(frame_latched)
   );

   always #5 clk = ~clk;

   // Registered image ROMs: either a constant colour or the address itself.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         rom_q[i] <= use_const[i] ? rom_const[i] : pixel_addr[i*AW +: AW];
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int h, input int v, input logic [11:0] rgb);
      in_hcount = 11'(h);
      in_vcount = 11'(v);
      in_rgb    = rgb;
   endtask

   task automatic run_pix(input int h, input int v, input logic [11:0] rgb);
      drive(h, v, rgb);
      tick(); tick(); tick();
   endtask

   task automatic vblank_pulse(input string tag);
      in_vblnk = 1'b1;
      #1;
      check({tag, "_pulse"}, 64'(frame_latched), 64'd1);
      tick();
      check({tag, "_pulse_end"}, 64'(frame_latched), 64'd0);
      in_vblnk = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_hsync = 1'b0; in_vsync = 1'b0; in_hblnk = 1'b0; in_vblnk = 1'b0;
      drive(0, 0, 12'h000);
      layer_en = '0;
      for (int i = 0; i < N; i++) begin
         lx[i] = '0; ly[i] = '0; rom_const[i] = '0; use_const[i] = 1'b0;
      end
      tick(); tick();
      check("rst_out_rgb",   64'(out_rgb), 64'h0);
      check("rst_out_hcnt",  64'(out_hcount), 64'h0);
      check("rst_addr",      64'(pixel_addr), 64'h0);
      check("rst_latched",   64'(frame_latched), 64'h0);

      // Configure before the first vblank rise; layers must still be off.
      layer_en = 4'b1111;
      lx[0] = 100;  ly[0] = 50;
      lx[1] = 200;  ly[1] = 200;
      lx[2] = 4070; ly[2] = 0;
      lx[3] = 200;  ly[3] = 200;
      rom_const[1] = 12'h111; use_const[1] = 1'b1;
      rom_const[2] = 12'h222; use_const[2] = 1'b1;
      rom_const[3] = 12'h333; use_const[3] = 1'b1;
      rst = 1'b0;
      run_pix(163, 113, 12'hABC);
      check("frame0_passthru", 64'(out_rgb), 64'hABC);
      check("frame0_addr",     64'(pixel_addr), 64'h0);
      check("frame0_nolatch",  64'(frame_latched), 64'h0);

      // Three-clock latency on a single-cycle hsync pulse.
      in_hsync = 1'b1;
      tick();
      in_hsync = 1'b0;
      tick();
      check("hsync_lat2", 64'(out_hsync), 64'd0);
      tick();
      check("hsync_lat3", 64'(out_hsync), 64'd1);
      tick();
      check("hsync_lat4", 64'(out_hsync), 64'd0);

      vblank_pulse("vb1");

      // Layer 0 bottom-right corner: address 4095, ROM echoes address.
      drive(163, 113, 12'h555);
      tick();
      check("corner_addr", 64'(pixel_addr), 64'h000_000_000_FFF);
      tick(); tick();
      check("corner_rgb",  64'(out_rgb), 64'hFFF);
      check("corner_hcnt", 64'(out_hcount), 64'd163);
      check("corner_vcnt", 64'(out_vcount), 64'd113);

      run_pix(164, 113, 12'h456);
      check("right_edge_rgb",  64'(out_rgb), 64'h456);
      check("right_edge_addr", 64'(pixel_addr), 64'h0);
      run_pix(100, 50, 12'h777);
      check("origin_rgb", 64'(out_rgb), 64'h000);
      run_pix(99, 50, 12'h777);
      check("left_edge_rgb", 64'(out_rgb), 64'h777);
      run_pix(101, 51, 12'hEEE);
      check("l0_addr65", 64'(pixel_addr), 64'h041);
      check("l0_rgb65",  64'(out_rgb), 64'h041);

      // Layers 1 and 3 overlap: layer 3 on top.
      run_pix(210, 205, 12'hEEE);
      check("overlap_rgb",  64'(out_rgb), 64'h333);
      check("overlap_addr", 64'(pixel_addr), 64'h14A_000_14A_000);

      // Disabling layer 3 mid-frame has no effect until the next vblank rise.
      layer_en = 4'b0111;
      run_pix(210, 205, 12'hEEE);
      check("midframe_dis", 64'(out_rgb), 64'h333);

      in_hblnk = 1'b1;
      run_pix(210, 205, 12'hABC);
      check("hblnk_rgb",  64'(out_rgb), 64'hABC);
      check("hblnk_flag", 64'(out_hblnk), 64'd1);
      in_hblnk = 1'b0;

      // Layer 2 at x=4070 never hits and never wraps.
      run_pix(0, 0, 12'h9A9);
      check("nowrap_h0", 64'(out_rgb), 64'h9A9);
      run_pix(37, 0, 12'h9A9);
      check("nowrap_h37", 64'(out_rgb), 64'h9A9);
      run_pix(2047, 10, 12'h9A9);
      check("nowrap_hmax",  64'(out_rgb), 64'h9A9);
      check("nowrap_addr",  64'(pixel_addr), 64'h0);

      vblank_pulse("vb2");
      run_pix(210, 205, 12'hEEE);
      check("l1_after_vb", 64'(out_rgb), 64'h111);
      run_pix(264, 205, 12'hEEE);
      check("l1_right_edge", 64'(out_rgb), 64'hEEE);

      // Config changes on the very rise cycle are captured.
      in_vblnk = 1'b1;
      layer_en = 4'b1001;
      lx[3] = 100; ly[3] = 50;
      rom_const[0] = 12'h123; use_const[0] = 1'b1;
      rom_const[3] = 12'h0F0;
      #1;
      check("vb3_pulse", 64'(frame_latched), 64'd1);
      tick();
      in_vblnk = 1'b0;
      run_pix(120, 60, 12'hEEE);
`ifdef SPRITE_KEY_EN
      check("key_colour", 64'(out_rgb), 64'h123);
`else
      check("key_colour", 64'(out_rgb), 64'h0F0);
`endif
      rom_const[3] = 12'h333;
      run_pix(120, 60, 12'hEEE);
      check("l3_over_l0", 64'(out_rgb), 64'h333);

      // Single-cycle reset in the active area.
      drive(120, 60, 12'hEEE);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_rgb",  64'(out_rgb), 64'h0);
      check("midrst_hcnt", 64'(out_hcount), 64'h0);
      check("midrst_addr", 64'(pixel_addr), 64'h0);
      run_pix(120, 60, 12'hBEE);
      check("midrst_off", 64'(out_rgb), 64'hBEE);
      vblank_pulse("vb4");
      run_pix(120, 60, 12'hBEE);
      check("midrst_back", 64'(out_rgb), 64'h333);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
